// File: rtl/iter_barrel_shifter.sv
// Multi-cycle barrel shifter: one conditional power-of-two stage per cycle
// (SLL/SRL/SRA/ROL), valid/ready on both sides, fixed latency of SHW cycles.
module iter_barrel_shifter #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [SHW-1:0]   k_q, k_d;
  logic [1:0]       mode_q, mode_d;
  logic             out_valid_q, out_valid_d;

  logic             accept, last_stage, stage_en;
  logic [SHW:0]     amt;
  logic [2*WIDTH-1:0] rot_w;
  logic [WIDTH-1:0] stage_res, work_nxt;

  // out_ready -> in_ready is the only combinational path through the block
  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign last_stage = (k_q == SHW'(SHW - 1));
  assign stage_en   = shamt_q[k_q];
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  // Stage k moves the working word by 2^k in the captured mode
  always_comb begin
    amt       = (SHW+1)'(1) << k_q;
    rot_w     = {work_q, work_q} << amt;
    stage_res = work_q;
    case (mode_q)
      2'b00: stage_res = work_q << amt;
      2'b01: stage_res = work_q >> amt;
      2'b10: stage_res = $unsigned($signed(work_q) >>> amt);
      2'b11: stage_res = rot_w[2*WIDTH-1:WIDTH];
      default: stage_res = work_q;
    endcase
    work_nxt = stage_en ? stage_res : work_q;
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    shamt_d     = shamt_q;
    k_d         = k_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    case (state_q)
      SHIFT: begin
        work_d = work_nxt;
        k_d    = k_q + SHW'(1);
        if (last_stage) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = work_nxt;
          k_d         = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    // A DONE handshake may accept in the same edge, skipping IDLE
    if (accept) begin
      state_d = SHIFT;
      work_d  = in_data;
      shamt_d = in_shamt;
      mode_d  = in_mode;
      k_d     = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      out_data_q  <= '0;
      shamt_q     <= '0;
      k_q         <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      shamt_q     <= shamt_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_iter_barrel_shifter.sv
// Bench for iter_barrel_shifter: latency/throughput model checked every cycle
// plus directed vectors with hand-computed results.
module tb_iter_barrel_shifter;
  localparam int W = 32;
  localparam int LAT = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [4:0]    in_shamt = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  iter_barrel_shifter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result of a whole shift straight from the mode definitions
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [4:0] s,
                                             input logic [1:0] m);
    logic [2*W-1:0] r;
    r = {d, d} << s;
    case (m)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: return $unsigned($signed(d) >>> s);
      default: return r[2*W-1:W];
    endcase
  endfunction

  // Timing model: a result appears LAT edges after acceptance and waits for out_ready
  int           m_busy = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_pend = '0;
  logic         m_ready;
  assign m_ready = (m_busy == 0 && !m_valid) || (m_valid && out_ready);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_valid = 1'b0; m_data = '0;
    end else begin
      logic acc, hs;
      acc = in_valid && m_ready;
      hs  = m_valid && out_ready;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_valid = 1'b1; m_data = m_pend; end
      end
      if (hs) m_valid = 1'b0;
      if (acc) begin m_pend = ref_shift(in_data, in_shamt, in_mode); m_busy = LAT; end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("model_in_ready", {31'b0, in_ready}, {31'b0, m_ready});
      chk("model_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("model_out_data", out_data, m_data);
    end
  end

  // Called at posedge+2 from IDLE; returns at posedge+2 with out_valid seen.
  task automatic issue_and_wait(input logic [W-1:0] d, input logic [4:0] s, input logic [1:0] m,
                                output int lat);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
    @(posedge clock); #2;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!out_valid && lat < 20);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] d, input logic [4:0] s,
                        input logic [1:0] m, input logic [W-1:0] exp);
    int lat;
    out_ready = 1'b1;
    issue_and_wait(d, s, m, lat);
    chk({nm, "_latency"}, W'(lat), W'(LAT));
    chk({nm, "_data"}, out_data, exp);
    @(posedge clock); #2;
    chk({nm, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
    chk({nm, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  typedef struct { logic [W-1:0] d; logic [4:0] s; logic [1:0] m; logic [W-1:0] e; } vec_t;
  vec_t vecs[$];

  initial begin
    int lat, t1, t2;
    logic [W-1:0] held;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #2;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);

    run_op("sll8", 32'h0000_00FF, 5'd8, 2'b00, 32'h0000_FF00);

    vecs.push_back('{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001});
    vecs.push_back('{32'h8000_0001, 5'd4,  2'b11, 32'h0000_0018});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF});
    vecs.push_back('{32'h7FFF_0000, 5'd16, 2'b10, 32'h0000_7FFF});
    vecs.push_back('{32'h1234_5678, 5'd8,  2'b11, 32'h3456_7812});
    vecs.push_back('{32'hF000_0000, 5'd1,  2'b01, 32'h7800_0000});
    vecs.push_back('{32'hC000_0005, 5'd3,  2'b10, 32'hF800_0000});
    vecs.push_back('{32'h0000_0001, 5'd21, 2'b00, 32'h0020_0000});
    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].m, vecs[i].e);

    // Backpressure: result must hold and new requests must be refused
    out_ready = 1'b0;
    issue_and_wait(32'h0000_000F, 5'd2, 2'b00, lat);
    chk("bp_latency", W'(lat), W'(LAT));
    held = out_data;
    chk("bp_data", held, 32'h0000_003C);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd1; in_mode = 2'b01;
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #2;
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_data", out_data, held);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #2;
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_retained_data", out_data, 32'h0000_003C);

    // Back-to-back: second accept rides on the first result's handshake edge
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd1; in_mode = 2'b00;
    @(posedge clock); #2;
    in_data = 32'h10; in_shamt = 5'd4; in_mode = 2'b01;
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (!out_valid && lat < 20);
    t1 = cyc;
    chk("b2b_first_lat", W'(lat), W'(LAT));
    chk("b2b_first_data", out_data, 32'h0000_0002);
    #1;
    @(posedge clock); #2;
    in_valid = 1'b0;
    chk("b2b_gap_valid", {31'b0, out_valid}, 32'd0);
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (!out_valid && lat < 20);
    t2 = cyc;
    chk("b2b_spacing", W'(t2 - t1), 32'd6);
    chk("b2b_second_data", out_data, 32'h0000_0001);
    #1;
    @(posedge clock); #2;

    // Asynchronous reset two cycles into SHIFT
    in_valid = 1'b1; in_data = 32'hABCD_0123; in_shamt = 5'd3; in_mode = 2'b11;
    @(posedge clock); #2;
    in_valid = 1'b0;
    @(posedge clock); @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_out_data", out_data, 32'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #2;
    repeat (LAT + 2) begin
      @(posedge clock); #2;
      chk("arst_no_stale", {31'b0, out_valid}, 32'd0);
    end
    run_op("post_rst_sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iter_barrel_shifter.md
Name: iter_barrel_shifter

Overview:
- Parametrised, multi-cycle successor to the fixed-amount, enable-controlled shift stages in the ALU datapath.
- Each cycle applies one conditional power-of-two stage (1, 2, 4, ..., WIDTH/2), selected by the matching bit of the shift amount.
- Supports four modes: logical left, logical right, arithmetic right and rotate left.
- Sits between the ALU issue logic and writeback. Uses valid/ready handshakes on both sides so a shift can stall without holding the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 2.
- SHW, $clog2(WIDTH), shift-amount width and number of shift stages (localparam, derived from WIDTH).

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  result; stable while out_valid=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, out_valid=0, out_data=0, stage counter=0, captured shamt/mode=0.
  - Reset mid-operation discards the in-flight shift with no output.
- States: IDLE, SHIFT, DONE.
- in_ready is combinational: 1 in IDLE; 1 in DONE when out_ready=1; otherwise 0.
- Accept: in_valid & in_ready at a rising edge.
  - Captures in_data into the working register, plus in_shamt and in_mode.
  - Clears the stage counter k to 0 and goes to SHIFT.
- SHIFT: on each edge, if shamt[k]=1, apply stage k to the working register (shift or rotate by 2^k); otherwise hold it. Then k increments.
  - SLL: vacated low bits are 0.
  - SRL: vacated high bits are 0.
  - SRA: vacated high bits take the current MSB, which preserves the operand sign through all stages.
  - ROL: bits shifted out of the MSB re-enter at bit 0.
  - When stage SHW-1 has been applied: go to DONE and set out_valid=1.
- Latency is fixed: out_valid rises exactly SHW edges after the accept edge (5 for WIDTH=32), independent of the shamt value. shamt=0 still takes SHW cycles and returns in_data unchanged.
- DONE: out_data and out_valid hold until out_valid & out_ready.
  - Handshake completes with no new accept: go to IDLE, out_valid=0 next edge.
  - Handshake completes together with a new accept (in_ready=1 via out_ready): go straight to SHIFT with the new operand. No idle bubble; out_valid=0 next edge.
- Throughput with out_ready held high and back-to-back requests: one result per SHW+1 cycles.
- in_valid in SHIFT is ignored (in_ready=0). Inputs other than at the accept edge have no effect.
- Unknown/illegal modes: none; all four encodings are defined.
- out_data is not updated in IDLE; it retains the last result.
- No combinational path from in_* to out_*. The only combinational path is out_ready to in_ready.

Test Plan:
1. Reset release, idle: in_ready=1, out_valid=0, out_data=0.
2. SLL, 0x000000FF, shamt=8, out_ready=1 -> out_valid rises exactly 5 edges after accept; out_data=0x0000FF00; returns to IDLE next edge.
3. SRA 0x80000000 shamt=31 -> 0xFFFFFFFF; SRL same operand -> 0x00000001; ROL 0x80000001 shamt=4 -> 0x00000018; any mode with shamt=0 on 0xDEADBEEF -> 0xDEADBEEF after 5 cycles.
4. Backpressure: out_ready=0 for 7 cycles after out_valid -> out_data and out_valid stable, in_ready=0, and a new in_valid is not accepted. out_ready=1 -> handshake completes, then IDLE.
5. Back-to-back: out_ready=1, in_valid held with SLL 1 shamt=1, then SRL 0x10 shamt=4 -> results 0x00000002 and 0x00000001 with exactly 6 cycles between the out_valid pulses; second accept occurs on the first result's handshake edge.
6. Reset asserted asynchronously 2 cycles into SHIFT -> out_valid=0 immediately, state IDLE. After release, a new SLL 0x1 shamt=31 -> 0x80000000 with normal latency and no stale result.
